// File: rtl/x_stretch.sv
// Pulse stretcher: turns 1-clock trigger pulses into a programmable-width level with
// optional retrigger and a minimum low gap. Define X_STRETCH_STATS_EN for merged/dropped counters.
module x_stretch #(
   parameter int CNT_BITS = 4,
   parameter int GAP      = 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                d,
   input  logic                enable,
   input  logic                retrig,
   input  logic [CNT_BITS-1:0] len,
`ifdef X_STRETCH_STATS_EN
   output logic [7:0]          merged,
   output logic [7:0]          dropped,
`endif
   output logic                q,
   output logic                busy
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_STRETCH = 2'd1;
   localparam logic [1:0] ST_HOLD    = 2'd2;
   localparam logic [3:0] GAP_V      = 4'(GAP);

   logic [1:0]          sm_r, sm_s;
   logic [CNT_BITS-1:0] cnt_r, cnt_s, load_s;
   logic [3:0]          gcnt_r, gcnt_s;
   logic                q_s, busy_s, trig_s, merge_s, drop_s;

   // A programmed length of zero still yields a one-clock pulse.
   function automatic logic [CNT_BITS-1:0] min_one(input logic [CNT_BITS-1:0] v);
      return (v == '0) ? CNT_BITS'(1'b1) : v;
   endfunction

   assign trig_s = d & enable;
   assign load_s = min_one(len);

   // Next-state, counter and output decode.
   always_comb begin
      sm_s    = sm_r;
      cnt_s   = cnt_r;
      gcnt_s  = gcnt_r;
      q_s     = q;
      busy_s  = busy;
      merge_s = 1'b0;
      drop_s  = 1'b0;
      if (!enable) begin
         sm_s   = ST_IDLE;
         cnt_s  = '0;
         gcnt_s = 4'd0;
         q_s    = 1'b0;
         busy_s = 1'b0;
      end else begin
         case (sm_r)
            ST_IDLE: begin
               if (trig_s) begin
                  sm_s   = ST_STRETCH;
                  cnt_s  = load_s;
                  q_s    = 1'b1;
                  busy_s = 1'b1;
               end else begin
                  q_s    = 1'b0;
                  busy_s = 1'b0;
               end
            end
            ST_STRETCH: begin
               if (trig_s && retrig) begin
                  // Reload beats the last-cycle exit so the level never glitches.
                  cnt_s   = load_s;
                  q_s     = 1'b1;
                  busy_s  = 1'b1;
                  merge_s = 1'b1;
               end else begin
                  drop_s = trig_s;
                  if (cnt_r <= CNT_BITS'(1'b1)) begin
                     cnt_s = '0;
                     q_s   = 1'b0;
                     if (GAP_V != 4'd0) begin
                        sm_s   = ST_HOLD;
                        gcnt_s = GAP_V;
                        busy_s = 1'b1;
                     end else begin
                        sm_s   = ST_IDLE;
                        busy_s = 1'b0;
                     end
                  end else begin
                     cnt_s  = cnt_r - CNT_BITS'(1'b1);
                     q_s    = 1'b1;
                     busy_s = 1'b1;
                  end
               end
            end
            ST_HOLD: begin
               drop_s = trig_s;
               q_s    = 1'b0;
               if (gcnt_r <= 4'd1) begin
                  sm_s   = ST_IDLE;
                  gcnt_s = 4'd0;
                  busy_s = 1'b0;
               end else begin
                  gcnt_s = gcnt_r - 4'd1;
                  busy_s = 1'b1;
               end
            end
            default: begin
               sm_s   = ST_IDLE;
               cnt_s  = '0;
               gcnt_s = 4'd0;
               q_s    = 1'b0;
               busy_s = 1'b0;
            end
         endcase
      end
   end

   // Core state and registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sm_r   <= ST_IDLE;
         cnt_r  <= '0;
         gcnt_r <= 4'd0;
         q      <= 1'b0;
         busy   <= 1'b0;
      end else begin
         sm_r   <= sm_s;
         cnt_r  <= cnt_s;
         gcnt_r <= gcnt_s;
         q      <= q_s;
         busy   <= busy_s;
      end
   end

`ifdef X_STRETCH_STATS_EN
   // Saturating event counters, cleared only by reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         merged  <= 8'd0;
         dropped <= 8'd0;
      end else begin
         if (merge_s && (merged != 8'hFF)) begin
            merged <= merged + 8'd1;
         end else begin
            merged <= merged;
         end
         if (drop_s && (dropped != 8'hFF)) begin
            dropped <= dropped + 8'd1;
         end else begin
            dropped <= dropped;
         end
      end
   end
`endif

endmodule

// File: tb/tb_x_stretch.sv
// Scoreboard bench for x_stretch (GAP=1): a timeline model pushes expected outputs per
// driven cycle; the values are popped and compared one clock later.
module tb_x_stretch;

   localparam int GAP = 1;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       d = 1'b0, enable = 1'b1, retrig = 1'b0;
   logic [3:0] len = 4'd0;
   logic       q, busy;
`ifdef X_STRETCH_STATS_EN
   logic [7:0] merged, dropped;
`endif

   x_stretch #(.CNT_BITS(4), .GAP(GAP)) dut (
      .clock(clock), .reset(reset), .d(d), .enable(enable), .retrig(retrig), .len(len),
`ifdef X_STRETCH_STATS_EN
      .merged(merged), .dropped(dropped),
`endif
      .q(q), .busy(busy)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic       q;
      logic       busy;
      logic [7:0] mg;
      logic [7:0] dp;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   hi_left = 0, gap_left = 0, m_mg = 0, m_dp = 0;
   int   high_seen = 0;

   task automatic check_val(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Timeline model: hi_left = high clocks still owed, gap_left = low clocks still owed.
   task automatic model_step();
      int lx;
      lx = (len == 4'd0) ? 1 : int'(len);
      if (reset) begin
         hi_left = 0; gap_left = 0; m_mg = 0; m_dp = 0;
      end else if (!enable) begin
         hi_left = 0; gap_left = 0;
      end else if (hi_left > 0) begin
         if (d && retrig) begin
            hi_left = lx;
            if (m_mg < 255) m_mg++;
         end else begin
            if (d && m_dp < 255) m_dp++;
            hi_left--;
            if (hi_left == 0) gap_left = GAP;
         end
      end else if (gap_left > 0) begin
         if (d && m_dp < 255) m_dp++;
         gap_left--;
      end else if (d) begin
         hi_left = lx;
      end
   endtask

   task automatic cycle(input logic d_i, input logic en_i, input logic rt_i, input logic [3:0] len_i);
      exp_t e;
      d = d_i; enable = en_i; retrig = rt_i; len = len_i;
      model_step();
      e.q = (hi_left > 0);
      e.busy = (hi_left > 0) || (gap_left > 0);
      e.mg = 8'(m_mg);
      e.dp = 8'(m_dp);
      sb_q.push_back(e);
      @(negedge clock);
      e = sb_q.pop_front();
      if (q) high_seen++;
      check_val("q", int'(q), int'(e.q));
      check_val("busy", int'(busy), int'(e.busy));
`ifdef X_STRETCH_STATS_EN
      check_val("merged", int'(merged), int'(e.mg));
      check_val("dropped", int'(dropped), int'(e.dp));
`endif
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, retrig, len);
   endtask

   initial begin
      @(negedge clock);
      // 1: pulses under reset have no effect
      for (int i = 0; i < 4; i++) cycle(i[0], 1'b1, 1'b0, 4'd3);
      reset = 1'b0;
      idle_cycles(2);

      // 2: len=3, single pulse -> 3 high clocks, one holdoff clock
      high_seen = 0;
      cycle(1'b1, 1'b1, 1'b0, 4'd3);
      idle_cycles(6);
      check_val("t2_width", high_seen, 3);

      // 3: retrigger merges two pulses into one 6-clock run
      high_seen = 0;
      cycle(1'b1, 1'b1, 1'b1, 4'd4);
      cycle(1'b0, 1'b1, 1'b1, 4'd4);
      cycle(1'b1, 1'b1, 1'b1, 4'd4);
      idle_cycles(7);
      check_val("t3_width", high_seen, 6);
`ifdef X_STRETCH_STATS_EN
      check_val("t3_merged", int'(merged), 1);
`endif

      // 4: no retrigger; second pulse and holdoff pulse are dropped
      high_seen = 0;
      cycle(1'b1, 1'b1, 1'b0, 4'd4);
      cycle(1'b0, 1'b1, 1'b0, 4'd4);
      cycle(1'b1, 1'b1, 1'b0, 4'd4);
      cycle(1'b0, 1'b1, 1'b0, 4'd4);
      cycle(1'b0, 1'b1, 1'b0, 4'd4);
      cycle(1'b1, 1'b1, 1'b0, 4'd4);
      idle_cycles(4);
      check_val("t4_width", high_seen, 4);
`ifdef X_STRETCH_STATS_EN
      check_val("t4_dropped", int'(dropped), 2);
`endif

      // 5: length boundaries and enable drop mid-stretch
      high_seen = 0;
      cycle(1'b1, 1'b1, 1'b0, 4'd0);
      idle_cycles(4);
      check_val("t5_len0", high_seen, 1);
      high_seen = 0;
      cycle(1'b1, 1'b1, 1'b0, 4'd15);
      idle_cycles(18);
      check_val("t5_len15", high_seen, 15);
      high_seen = 0;
      cycle(1'b1, 1'b1, 1'b0, 4'd8);
      idle_cycles(2);
      cycle(1'b0, 1'b0, 1'b0, 4'd8);
      idle_cycles(10);
      check_val("t5_enable", high_seen, 3);

      // 6: async reset between edges clears outputs immediately
      cycle(1'b1, 1'b1, 1'b0, 4'd15);
      idle_cycles(3);
      #2 reset = 1'b1;
      #1;
      check_val("t6_async_q", int'(q), 0);
      check_val("t6_async_busy", int'(busy), 0);
      hi_left = 0; gap_left = 0; m_mg = 0; m_dp = 0;
      @(negedge clock);
      reset = 1'b0;
      idle_cycles(2);
      for (int i = 0; i < 340; i++) cycle(1'b1, 1'b1, 1'b0, 4'd15);
`ifdef X_STRETCH_STATS_EN
      check_val("t6_saturate", int'(dropped), 255);
`endif
      idle_cycles(3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
